// File: rtl/display_scan_ctrl.sv
// 4-digit 7-segment display controller: handshaked binary input, iterative shift-add-3
// binary-to-BCD conversion, and a multiplexed scanner through one shared segment decoder.

module BCD_module (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  // Active-low segments ordered {g,f,e,d,c,b,a}; non-decimal codes go dark.
  always_comb begin
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

module display_scan_ctrl #(
  parameter int N_in        = 10,
  parameter int N_out       = 7,
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_in-1:0]  bin_in,
  input  logic             bin_valid,
  output logic             bin_ready,
  input  logic             blank_lz,
  output logic [N_out-1:0] seg,
  output logic [3:0]       an,
  output logic [15:0]      digits,
  output logic             done,
  output logic             overflow
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;
  localparam int PW = $clog2(REFRESH_DIV + 1);

  logic [1:0]      state;
  logic [15:0]     bcd;
  logic [N_in-1:0] bin_sr;
  logic [4:0]      cnt;
  logic [PW-1:0]   pre;
  logic [1:0]      idx;
  logic [1:0]      idx_nxt;
  logic [3:0]      cur_digit;
  logic [6:0]      seg7;

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int k = 0; k < 4; k++)
      if (r[k*4 +: 4] >= 4'd5) r[k*4 +: 4] = r[k*4 +: 4] + 4'd3;
    return r;
  endfunction

  // Digit k>0 is dark when it and every more significant digit are zero.
  function automatic logic blanked(input logic [15:0] d, input logic [1:0] k, input logic bl);
    return bl && (k != 2'd0) && ((d >> {k, 2'b00}) == 16'd0);
  endfunction

  assign bin_ready = (state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      bcd      <= '0;
      bin_sr   <= '0;
      cnt      <= '0;
      digits   <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (bin_valid) begin
          bcd   <= '0;
          cnt   <= '0;
          state <= S_SHIFT;
          if (32'(bin_in) > 32'd9999) begin
            bin_sr   <= N_in'(9999);
            overflow <= 1'b1;
          end else begin
            bin_sr   <= bin_in;
            overflow <= 1'b0;
          end
        end
        S_SHIFT: begin
          {bcd, bin_sr} <= {add3(bcd), bin_sr} << 1;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(N_in - 1)) state <= S_LATCH;
        end
        S_LATCH: begin
          digits <= bcd;
          done   <= 1'b1;
          state  <= S_HOLD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Scanner: free-running prescaler, anode pattern refreshed only when idx advances.
  assign idx_nxt = idx + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      idx <= 2'd0;
      an  <= 4'b1110;
    end else if (pre == PW'(REFRESH_DIV - 1)) begin
      pre <= '0;
      idx <= idx_nxt;
      an  <= blanked(digits, idx_nxt, blank_lz) ? 4'b1111 : ~(4'b0001 << idx_nxt);
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign cur_digit = digits[{idx, 2'b00} +: 4];

  BCD_module u_dec (
    .bcd (cur_digit),
    .seg (seg7)
  );

  assign seg = N_out'(seg7);

endmodule
